permutation_engine: RTL and testbench

PERMUTATION_ENGINE -- requirements
Module: permutation_engine

---
 rtl/permutation_engine.sv | 136 +++++++++++++
 tb/tb_permutation_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/permutation_engine.sv
// Iterated bit-matrix permutation engine: cell (x,y) moves to (y,(2x+3y) mod N) each round.
// Optional feature macro PERM_INVERSE_EN adds a per-job inverse-map select.
module permutation_engine #(
    parameter int N      = 5,
    parameter int ROUNDS = 64,
    localparam int RB    = $clog2(ROUNDS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*N-1:0]  matrix_in,
    input  logic [RB-1:0]   num_rounds,
    input  logic            inverse,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*N-1:0]  matrix_out,
    output logic            busy,
    output logic [RB-1:0]   round_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [RB-1:0] MAX_ROUNDS = RB'(ROUNDS);

    state_t          state_q, state_d;
    logic [N*N-1:0]  matrix_q, matrix_d;
    logic [RB-1:0]   round_cnt_q, round_cnt_d;
    logic [RB-1:0]   rounds_q, rounds_d;
    logic [RB-1:0]   rounds_sat;
    logic [N*N-1:0]  fwd_map;
    logic [N*N-1:0]  next_matrix;

    assign rounds_sat = (num_rounds > MAX_ROUNDS) ? MAX_ROUNDS : num_rounds;

    // Source cell (x,y) lands at bit ((2x+3y) mod N)*N + y.
    always_comb begin
        fwd_map = '0;
        for (int y = 0; y < N; y++) begin
            for (int x = 0; x < N; x++) begin
                fwd_map[((2*x + 3*y) % N)*N + y] = matrix_q[y*N + x];
            end
        end
    end

`ifdef PERM_INVERSE_EN
    logic            inverse_q, inverse_d;
    logic [N*N-1:0]  inv_map;

    // Inverse pulls each cell back from where the forward map would send it.
    always_comb begin
        inv_map = '0;
        for (int y = 0; y < N; y++) begin
            for (int x = 0; x < N; x++) begin
                inv_map[y*N + x] = matrix_q[((2*x + 3*y) % N)*N + y];
            end
        end
    end

    assign next_matrix = inverse_q ? inv_map : fwd_map;
`else
    logic unused_inverse;

    assign unused_inverse = inverse;
    assign next_matrix    = fwd_map;
`endif

    always_comb begin
        state_d     = state_q;
        matrix_d    = matrix_q;
        round_cnt_d = round_cnt_q;
        rounds_d    = rounds_q;
`ifdef PERM_INVERSE_EN
        inverse_d   = inverse_q;
`endif
        if (abort) begin
            state_d     = IDLE;
            round_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        matrix_d    = matrix_in;
                        rounds_d    = rounds_sat;
                        round_cnt_d = '0;
`ifdef PERM_INVERSE_EN
                        inverse_d   = inverse;
`endif
                        state_d     = (rounds_sat != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    matrix_d    = next_matrix;
                    round_cnt_d = round_cnt_q + RB'(1);
                    if (round_cnt_d == rounds_q) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            matrix_q    <= '0;
            round_cnt_q <= '0;
            rounds_q    <= '0;
`ifdef PERM_INVERSE_EN
            inverse_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            matrix_q    <= matrix_d;
            round_cnt_q <= round_cnt_d;
            rounds_q    <= rounds_d;
`ifdef PERM_INVERSE_EN
            inverse_q   <= inverse_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == RUN);
    assign matrix_out = matrix_q;
    assign round_cnt  = round_cnt_q;

endmodule

// File: tb/tb_permutation_engine.sv
// Directed bench for permutation_engine (N=5, ROUNDS=64) with hand-computed expectations.
module tb_permutation_engine;

    localparam int N      = 5;
    localparam int ROUNDS = 64;
    localparam int RB     = $clog2(ROUNDS + 1);

    logic            clk;
    logic            rst;
    logic            abort;
    logic            in_valid;
    logic            in_ready;
    logic [N*N-1:0]  matrix_in;
    logic [RB-1:0]   num_rounds;
    logic            inverse;
    logic            out_valid;
    logic            out_ready;
    logic [N*N-1:0]  matrix_out;
    logic            busy;
    logic [RB-1:0]   round_cnt;

    int total = 0;
    int bad   = 0;

    permutation_engine #(.N(N), .ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .matrix_in  (matrix_in),
        .num_rounds (num_rounds),
        .inverse    (inverse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .matrix_out (matrix_out),
        .busy       (busy),
        .round_cnt  (round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one job for exactly one clock edge (the accept edge).
    task automatic applyStimulus(input logic [N*N-1:0] mat, input int rounds, input logic inv);
        matrix_in  = mat;
        num_rounds = RB'(rounds);
        inverse    = inv;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        inverse    = 1'b0;
        matrix_in  = '0;
        num_rounds = '0;
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid, bounded.
    task automatic waitResult(input int expected_cycles, input string tag);
        int cycles;
        cycles = 1;
        while (!out_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, expected_cycles);
        checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [N*N-1:0] rand_mat;
        logic [N*N-1:0] inv_expect;

        rst        = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        matrix_in  = '0;
        num_rounds = '0;
        inverse    = 1'b0;
        out_ready  = 1'b0;

        tick();
        tick();
        rst = 1'b1;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_matrix", matrix_out, 32'd0);
        checkOutput("reset_round_cnt", round_cnt, 32'd0);

        // One forward round: bit 1 -> bit 10.
        applyStimulus(25'd1 << 1, 1, 1'b0);
        checkOutput("r1_busy", {31'b0, busy}, 32'd1);
        waitResult(2, "r1");
        checkOutput("r1_matrix", matrix_out, 32'd1 << 10);
        checkOutput("r1_round_cnt", round_cnt, 32'd1);
        checkOutput("r1_in_ready_done", {31'b0, in_ready}, 32'd0);
        // in_valid during the releasing DONE cycle must not start a new job.
        in_valid  = 1'b1;
        matrix_in = 25'h155_5555;
        num_rounds = RB'(3);
        releaseResult();
        in_valid  = 1'b0;
        checkOutput("r1_back_idle", {31'b0, in_ready}, 32'd1);
        checkOutput("r1_no_reaccept_busy", {31'b0, busy}, 32'd0);
        tick();
        checkOutput("r1_still_idle", {31'b0, in_ready}, 32'd1);

        // Two rounds: bit 1 -> 10 -> 7.
        applyStimulus(25'd1 << 1, 2, 1'b0);
        waitResult(3, "r2");
        checkOutput("r2_matrix", matrix_out, 32'd1 << 7);
        releaseResult();

        // Zero rounds passes the matrix straight through.
        applyStimulus(25'h1AB_CDEF, 0, 1'b0);
        waitResult(1, "r0");
        checkOutput("r0_matrix", matrix_out, 32'h1AB_CDEF);
        checkOutput("r0_round_cnt", round_cnt, 32'd0);
        releaseResult();

        // The forward map has order 24 for N=5.
        rand_mat = 25'($urandom);
        applyStimulus(rand_mat, 24, 1'b0);
        waitResult(25, "r24");
        checkOutput("r24_matrix", matrix_out, {7'b0, rand_mat});
        checkOutput("r24_round_cnt", round_cnt, 32'd24);
        releaseResult();

`ifdef PERM_INVERSE_EN
        inv_expect = 25'd1 << 1;
`else
        inv_expect = 25'd1 << 7;
`endif
        applyStimulus(25'd1 << 10, 1, 1'b1);
        waitResult(2, "inv");
        checkOutput("inv_matrix", matrix_out, {7'b0, inv_expect});
        releaseResult();

        applyStimulus(25'd1, 1, 1'b1);
        waitResult(2, "center_inv");
        checkOutput("center_inv_matrix", matrix_out, 32'd1);
        releaseResult();

        applyStimulus(25'd1, 1, 1'b0);
        waitResult(2, "center_fwd");
        checkOutput("center_fwd_matrix", matrix_out, 32'd1);
        releaseResult();

        // ROUNDS+1 requested saturates to ROUNDS.
        applyStimulus(25'd1, ROUNDS + 1, 1'b0);
        waitResult(ROUNDS + 1, "sat");
        checkOutput("sat_round_cnt", round_cnt, 32'd64);
        checkOutput("sat_matrix", matrix_out, 32'd1);
        releaseResult();

        // Result holds while out_ready is low, even with in_valid asserted.
        applyStimulus(25'd1 << 1, 1, 1'b0);
        waitResult(2, "hold");
        in_valid   = 1'b1;
        matrix_in  = 25'h0F0_F0F0;
        num_rounds = RB'(5);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_matrix", matrix_out, 32'd1 << 10);
            checkOutput("hold_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("hold_round_cnt", round_cnt, 32'd1);
        end
        in_valid   = 1'b0;
        num_rounds = '0;
        releaseResult();

        // Abort after 10 rounds; bit 1 orbit reaches bit 21 at round 10.
        applyStimulus(25'd1 << 1, 20, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("abort_pre_cnt", round_cnt, 32'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("abort_round_cnt", round_cnt, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_matrix_kept", matrix_out, 32'd1 << 21);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_no_out_valid", {31'b0, out_valid}, 32'd0);
        end

        // Abort wins over a simultaneous accept.
        in_valid   = 1'b1;
        matrix_in  = 25'h123_4567;
        num_rounds = RB'(4);
        abort      = 1'b1;
        tick();
        abort      = 1'b0;
        in_valid   = 1'b0;
        checkOutput("abort_vs_accept_idle", {31'b0, in_ready}, 32'd1);
        checkOutput("abort_vs_accept_matrix", matrix_out, 32'd1 << 21);

        // Reset mid-run discards the job.
        applyStimulus(25'd1 << 1, 20, 1'b0);
        tick();
        tick();
        tick();
        rst   = 1'b0;
        abort = 1'b1;
        tick();
        rst   = 1'b1;
        abort = 1'b0;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_matrix", matrix_out, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_round_cnt", round_cnt, 32'd0);
        for (int i = 0; i < 25; i++) begin
            tick();
            checkOutput("rst_no_out_valid", {31'b0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
